// File: rtl/lwb_pkg.sv
// rtl/lwb_pkg.sv - shared types and constants for the line window buffer
package lwb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } lwb_state_t;

    localparam int MAX_LINE_W = 4096;
    localparam int ROW_W      = $clog2(MAX_LINE_W);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

endpackage

// File: rtl/lwb_line_ram.sv
// rtl/lwb_line_ram.sv - simple dual-port line store, 1-cycle registered read, read-before-write
module lwb_line_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1280,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; an access colliding with a write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_window_buf.sv
// rtl/line_window_buf.sv - vertical TAPS-line column window generator (option: LWB_BORDER_REPLICATE_EN)
module line_window_buf
    import lwb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LINE_W = 1280,
    parameter int TAPS   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    output logic [TAPS*DATA_W-1:0] out_data,
    output logic                   out_sol,
    output logic                   out_eol,
    output logic [ROW_W-1:0]       out_row
);

    localparam int COL_W = $clog2(LINE_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] FILL_ROW = ROW_W'(TAPS - 2);

    lwb_state_t state, state_nxt;
    logic [COL_W-1:0] col, pix_col, wr_col_q;
    logic [ROW_W-1:0] row, pix_row;
    logic accept, wrap, valid_nxt, wr_en_q;
    logic [DATA_W-1:0] cur_q;
    logic [TAPS-2:0][DATA_W-1:0] ram_rd;
    logic [TAPS-1:0][DATA_W-1:0] win;

    // A start-of-frame pixel is always column 0, row 0 regardless of the counters.
    assign accept  = in_valid & (in_sof | (state != IDLE));
    assign pix_col = in_sof ? '0 : col;
    assign pix_row = in_sof ? '0 : row;
    assign wrap    = accept & (pix_col == COL_LAST);
    assign win     = {ram_rd, cur_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output-valid.
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        case (state)
            IDLE:    if (in_valid && in_sof) state_nxt = FILL;
            FILL: begin
                if (in_valid && in_sof)                 state_nxt = FILL;
                else if (wrap && (pix_row == FILL_ROW)) state_nxt = RUN;
            end
            RUN:     if (in_valid && in_sof) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
`ifdef LWB_BORDER_REPLICATE_EN
        valid_nxt = accept;
`else
        valid_nxt = in_valid & ~in_sof & (state == RUN);
`endif
    end

    // Column/row counters hold the position of the next pixel; row saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (wrap) begin
                col <= '0;
                row <= (pix_row == ROW_MAX) ? ROW_MAX : pix_row + 1'b1;
            end else begin
                col <= pix_col + 1'b1;
                row <= pix_row;
            end
        end
    end

    // Pixel pipeline: the window word read this cycle is written back one slot down the chain next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q  <= 1'b0;
            wr_col_q <= '0;
            cur_q    <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_col_q <= pix_col;
                cur_q    <= in_data;
            end
        end
    end

    // Output flags describe the pixel accepted on the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_row   <= '0;
        end else begin
            out_valid <= valid_nxt;
            if (accept) begin
                out_sol <= (pix_col == '0);
                out_eol <= (pix_col == COL_LAST);
                out_row <= pix_row;
            end
        end
    end

    // Store k holds the line k+1 lines above the current one.
    for (genvar k = 0; k < TAPS - 1; k++) begin : g_store
        lwb_line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (LINE_W),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en_q),
            .wr_addr (wr_col_q),
            .wr_data (win[k]),
            .rd_en   (accept),
            .rd_addr (pix_col),
            .rd_data (ram_rd[k])
        );
    end

`ifdef LWB_BORDER_REPLICATE_EN
    logic [TAPS-1:0][DATA_W-1:0] rep;

    // Slices above the top of the frame repeat the oldest line actually stored (row 0).
    always_comb begin
        rep = win;
        for (int j = 1; j < TAPS; j++) begin
            for (int s = 0; s < j; s++) begin
                if (out_row == ROW_W'(s)) rep[j] = win[s];
            end
        end
    end

    assign out_data = rep;
`else
    assign out_data = win;
`endif

endmodule

// File: tb/tb_line_window_buf.sv
// tb/tb_line_window_buf.sv - randomized self-checking bench against a frame-level reference model
module tb_line_window_buf;

    localparam int DATA_W = 8;
    localparam int LINE_W = 4;
    localparam int TAPS   = 3;
    localparam int ROW_W  = 12;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_sof = 1'b0;
    logic [DATA_W-1:0]      in_data = '0;
    logic                   out_valid;
    logic [TAPS*DATA_W-1:0] out_data;
    logic                   out_sol;
    logic                   out_eol;
    logic [ROW_W-1:0]       out_row;

    int n_checks = 0;
    int n_fail   = 0;
    int n_windows = 0;

    // reference model: the whole current frame in raster order
    bit               m_active = 0;
    int               m_row = 0;
    int               m_col = 0;
    logic [7:0]       frame_q[$];
    bit               exp_valid;
    bit               exp_sol, exp_eol;
    int               exp_row;
    logic [TAPS*DATA_W-1:0] exp_data;

    line_window_buf #(.DATA_W(DATA_W), .LINE_W(LINE_W), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_row = 0;
        m_col = 0;
        frame_q.delete();
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] d);
        int pos, back;
        exp_valid = 0;
        if (v && s) begin
            m_active = 1;
            m_row = 0;
            m_col = 0;
            frame_q.delete();
        end
        if (v && m_active) begin
            frame_q.push_back(d);
            pos = frame_q.size() - 1;
`ifdef LWB_BORDER_REPLICATE_EN
            exp_valid = 1;
`else
            exp_valid = (m_row >= TAPS - 1);
`endif
            exp_data = '0;
            for (int j = 0; j < TAPS; j++) begin
                back = (m_row < j) ? m_row : j;
                exp_data[j*DATA_W +: DATA_W] = frame_q[pos - back*LINE_W];
            end
            exp_sol = (m_col == 0);
            exp_eol = (m_col == LINE_W - 1);
            exp_row = m_row;
            m_col++;
            if (m_col == LINE_W) begin
                m_col = 0;
                m_row = (m_row < 4095) ? m_row + 1 : 4095;
            end
        end
    endtask

    task automatic send(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            n_windows++;
            check("out_data", 64'(out_data), 64'(exp_data));
            check("out_sol", 64'(out_sol), 64'(exp_sol));
            check("out_eol", 64'(out_eol), 64'(exp_eol));
            check("out_row", 64'(out_row), 64'(exp_row));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_sol"}, 64'(out_sol), 64'd0);
        check({tag, "_eol"}, 64'(out_eol), 64'd0);
        check({tag, "_row"}, 64'(out_row), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // pixels in IDLE without a start of frame are ignored
        for (int i = 0; i < 6; i++) send(1, 0, 8'(8'h40 + i));

        // contiguous ramp frame: windows only for pixels 8..11
        n_windows = 0;
        for (int i = 0; i < 12; i++) send(1, i == 0, 8'(i));
        send(0, 0, 8'h00);
        check("ramp_windows", 64'(n_windows), 64'd4);

        // same ramp with random gaps
        n_windows = 0;
        for (int i = 0; i < 12; i++) begin
            while ($urandom_range(0, 2) == 0) send(0, 0, 8'($urandom));
            send(1, i == 0, 8'(i));
        end
        send(0, 0, 8'h00);
        check("gap_windows", 64'(n_windows), 64'd4);

        // start of frame reasserted at pixel 9
        n_windows = 0;
        for (int i = 0; i < 21; i++) send(1, (i == 0) || (i == 9), 8'(8'h80 + i));
        check("resof_windows", 64'(n_windows), 64'd5);

        // asynchronous reset in the middle of RUN
        for (int i = 0; i < 3; i++) send(1, 0, 8'($urandom));
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) send(1, 0, 8'($urandom));

        // long random traffic with occasional restarts
        for (int i = 0; i < 600; i++) begin
            send($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0 || i == 0, 8'($urandom));
        end
        send(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_window_buf.md
LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 Parameter DATA_W, 8, bits per pixel component.
REQ-002 Parameter LINE_W, 1280, pixels per line; legal range 2..4096.
REQ-003 Parameter TAPS, 3, vertical window height (lines); legal range 2..8.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  pixel present on in_data this cycle.
REQ-007 in_sof  input  1  first pixel of frame; qualified by in_valid.
REQ-008 in_data  input  DATA_W  pixel, raster order.
REQ-009 out_valid  output  1  out_data holds a valid column window.
REQ-010 out_data  output  TAPS*DATA_W  vertical window, MSB slice = oldest line, LSB slice = current line.
REQ-011 out_sol / out_eol  output  1 each  window is first / last column of a line.
REQ-012 out_row  output  $clog2(4096)  row index of current (LSB) line within frame.

Function
REQ-013 No backpressure; every in_valid pixel SHALL be accepted.
REQ-014 Column counter SHALL advance per accepted pixel, wrap LINE_W-1 -> 0, and increment row counter on wrap.
REQ-015 TAPS-1 line stores SHALL form a delay chain: store k at column c read then overwritten with store k-1's (or in_data's for k=0) value at that column, same cycle.
REQ-016 State machine states IDLE, FILL, RUN; reset -> IDLE.
REQ-017 IDLE -> FILL on in_valid & in_sof; FILL -> RUN on column wrap ending line TAPS-2 (i.e. TAPS-1 full lines stored); RUN holds until next in_sof.
REQ-018 in_sof with in_valid in any state SHALL zero column and row counters and enter FILL, discarding stored lines as invalid (contents need not be cleared).
REQ-019 in_valid without prior in_sof (IDLE) SHALL be ignored.
REQ-020 Outputs SHALL be registered; latency in_valid -> out_valid exactly 1 cycle.
REQ-021 In RUN, out_valid SHALL equal in_valid delayed one cycle; out_sol/out_eol/out_row describe that pixel.
REQ-022 In IDLE and FILL, out_valid SHALL be 0 (unless REQ-027 applies).
REQ-023 Row counter SHALL saturate at 4095; column counter width $clog2(LINE_W).
REQ-024 Pixels between in_valid gaps SHALL not corrupt alignment; only accepted pixels advance counters.

Reset
REQ-025 On rst_n low: state IDLE, counters 0, out_valid/out_sol/out_eol 0, out_data 0, out_row 0; line-store contents undefined.
REQ-026 Reset mid-frame SHALL abandon the frame; output resumes only after next in_sof plus fill.

Configuration
REQ-027 Macro LWB_BORDER_REPLICATE_EN defined: in FILL, out_valid follows in_valid and slices for lines not yet stored SHALL replicate the oldest valid line (row 0 window = TAPS copies of in_data); not defined: REQ-022 holds, no replication logic synthesised.

Structure
REQ-028 Package lwb_pkg SHALL hold state enum (IDLE, FILL, RUN), MAX_LINE_W=4096, ROW_W constant.
REQ-029 Sub-module lwb_line_ram: simple dual-port RAM, depth LINE_W, width DATA_W, 1-cycle read, read-before-write; TAPS-1 instances.

Verification (LINE_W=4, TAPS=3, DATA_W=8 unless stated)
REQ-030 Reset then in_sof + 12 pixels 0x00..0x0B -> out_valid only for pixels 8..11; first out_data {0x00,0x04,0x08}, out_sol=1, out_row=2; last {0x03,0x07,0x0B}, out_eol=1.
REQ-031 Same stream with random in_valid gaps -> identical window sequence, each out_valid one cycle after its in_valid.
REQ-032 in_sof reasserted at pixel 9 -> out_valid drops next cycle, row 0, no output until 8 further pixels.
REQ-033 rst_n low for one cycle mid-RUN -> outputs 0 immediately (async); pixels without in_sof ignored.
REQ-034 LWB_BORDER_REPLICATE_EN defined, first pixel 0x00 -> out_data {0x00,0x00,0x00}, out_valid=1; pixel 4 -> {0x00,0x00,0x04}.
REQ-035 LINE_W=1280, TAPS=5, 1280x8 ramp frame -> 4 rows of 1280 windows, each slice = pixel one line (1280) apart.
